// File: rtl/display_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment display path.
package display_pkg;

   localparam int         DIGIT_W    = 4;
   localparam int         MAX_DIGITS = 8;
   localparam logic [7:0] SEG_BLANK  = 8'hFF;
   localparam logic [6:0] SEG7_BLANK = 7'h7F;
   // Level of a single anode line when its digit is dark (common anode, active-low).
   localparam logic       AN_OFF     = 1'b1;

   // Leading-zero blank vector: bit k is set when digits n-1..k are all zero and k is not 0.
   function automatic logic [MAX_DIGITS-1:0] lz_mask(
      input logic [MAX_DIGITS*DIGIT_W-1:0] bcd,
      input int                            n
   );
      logic [MAX_DIGITS-1:0] mask;
      logic                  all_zero;
      mask     = '0;
      all_zero = 1'b1;
      for (int k = MAX_DIGITS - 1; k >= 0; k--) begin
         if (k < n) begin
            all_zero = all_zero & (bcd[k*DIGIT_W +: DIGIT_W] == '0);
            mask[k]  = all_zero && (k != 0);
         end
      end
      return mask;
   endfunction

endpackage

// File: rtl/segment_decoder.sv
// BCD to active-low 7-segment decoder. Output is {dp,g,f,e,d,c,b,a};
// the dp bit is always driven off, codes 10..15 decode to all segments off.
module segment_decoder
   import display_pkg::*;
(
   input  logic [DIGIT_W-1:0] digit,
   output logic [7:0]         seg_n
);

   // Pure lookup, no state.
   always_comb begin
      case (digit)
         4'd0:    seg_n = 8'hC0;
         4'd1:    seg_n = 8'hF9;
         4'd2:    seg_n = 8'hA4;
         4'd3:    seg_n = 8'hB0;
         4'd4:    seg_n = 8'h99;
         4'd5:    seg_n = 8'h92;
         4'd6:    seg_n = 8'h82;
         4'd7:    seg_n = 8'hF8;
         4'd8:    seg_n = 8'h80;
         4'd9:    seg_n = 8'h90;
         default: seg_n = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed scan controller for an N-digit common-anode display.
// Holds a shadow copy of the digits that only changes on frame boundaries,
// blanks all anodes for a guard window at the start of every slot, and
// optionally suppresses leading zeros.
module seven_seg_scanner
   import display_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int SCAN_DIV   = 100000,
   parameter int GUARD      = 16
)
(
   input  logic                          clk,
   input  logic                          rst,
   input  logic [DIGIT_W*NUM_DIGITS-1:0] bcd,
   input  logic [NUM_DIGITS-1:0]         dp_en,
   input  logic                          blank_lz,
   input  logic                          load,
   output logic [NUM_DIGITS-1:0]         an,
   output logic [7:0]                    seg,
   output logic                          frame_done
);

   localparam int CNT_W = $clog2(SCAN_DIV);
   localparam int IDX_W = (NUM_DIGITS < 2) ? 1 : $clog2(NUM_DIGITS);
   localparam int BCD_W = DIGIT_W * NUM_DIGITS;
   localparam logic [NUM_DIGITS-1:0] AN_ALL_OFF = {NUM_DIGITS{AN_OFF}};

   // Scan position
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic                  slot_end;
   logic                  last_idx;
   logic                  idx_valid;
   logic                  frame_end;

   // Staging (written by load) and shadow (what is displayed)
   logic [BCD_W-1:0]      stage_bcd_q;
   logic [NUM_DIGITS-1:0] stage_dp_q;
   logic                  stage_lz_q;
   logic                  pending_q;
   logic [BCD_W-1:0]      shadow_bcd_q;
   logic [NUM_DIGITS-1:0] shadow_dp_q;
   logic                  shadow_lz_q;

   // Digit selection and decode
   logic [DIGIT_W-1:0]    digit_arr [NUM_DIGITS];
   logic [DIGIT_W-1:0]    sel_digit;
   logic                  sel_dp;
   logic                  sel_blank;
   logic [MAX_DIGITS-1:0] lz_vec;
   logic [7:0]            dec_seg;

   // Output registers
   logic [NUM_DIGITS-1:0] an_q, an_d;
   logic [7:0]            seg_q, seg_d;
   logic                  frame_done_q;

   // Split the shadow word into per-digit nibbles.
   generate
      for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
         assign digit_arr[gi] = shadow_bcd_q[gi*DIGIT_W +: DIGIT_W];
      end
   endgenerate

   assign idx_valid = (int'(idx_q) < NUM_DIGITS);
   assign lz_vec    = lz_mask((MAX_DIGITS*DIGIT_W)'(shadow_bcd_q), NUM_DIGITS);

   // Next slot counter and digit index; the index only moves when a slot ends.
   always_comb begin
      slot_end  = (cnt_q == CNT_W'(SCAN_DIV - 1));
      last_idx  = (idx_q == IDX_W'(NUM_DIGITS - 1));
      frame_end = slot_end && last_idx;
      cnt_d     = slot_end ? '0 : cnt_q + CNT_W'(1);
      idx_d     = idx_q;
      if (slot_end) begin
         idx_d = (last_idx || !idx_valid) ? '0 : idx_q + IDX_W'(1);
      end
   end

   // Advance the scan position.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         idx_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         idx_q <= idx_d;
      end
   end

   // Stage loads and promote them to the shadow only at the frame boundary,
   // so a frame never shows a mix of old and new digits.
   always_ff @(posedge clk) begin
      if (rst) begin
         stage_bcd_q  <= '0;
         stage_dp_q   <= '0;
         stage_lz_q   <= 1'b0;
         pending_q    <= 1'b0;
         shadow_bcd_q <= '0;
         shadow_dp_q  <= '0;
         shadow_lz_q  <= 1'b0;
      end else begin
         if (frame_end && pending_q) begin
            shadow_bcd_q <= stage_bcd_q;
            shadow_dp_q  <= stage_dp_q;
            shadow_lz_q  <= stage_lz_q;
            pending_q    <= 1'b0;
         end
         // A load on the boundary cycle itself is kept for the following frame.
         if (load) begin
            stage_bcd_q <= bcd;
            stage_dp_q  <= dp_en;
            stage_lz_q  <= blank_lz;
            pending_q   <= 1'b1;
         end
      end
   end

   // Pick the digit, dp request and blank flag for the current index.
   always_comb begin
      sel_digit = '1;
      sel_dp    = 1'b0;
      sel_blank = 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (int'(idx_q) == k) begin
            sel_digit = digit_arr[k];
            sel_dp    = shadow_dp_q[k];
         end
      end
      for (int k = 0; k < MAX_DIGITS; k++) begin
         if (int'(idx_q) == k) begin
            sel_blank = shadow_lz_q & lz_vec[k];
         end
      end
   end

   segment_decoder u_dec (
      .digit (sel_digit),
      .seg_n (dec_seg)
   );

   // Compose next anode/segment values: dark during guard or on an unused index.
   always_comb begin
      an_d  = AN_ALL_OFF;
      seg_d = SEG_BLANK;
      if ((cnt_q >= CNT_W'(GUARD)) && idx_valid) begin
         for (int k = 0; k < NUM_DIGITS; k++) begin
            if (int'(idx_q) == k) begin
               an_d[k] = ~AN_OFF;
            end
         end
         // Decoder always reports dp off, so a dp request pulls bit 7 low.
         seg_d[7]   = ~(sel_dp & dec_seg[7]);
         seg_d[6:0] = sel_blank ? SEG7_BLANK : dec_seg[6:0];
      end
   end

   // Registered pins; frame_done marks the first cycle of a new frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         an_q         <= AN_ALL_OFF;
         seg_q        <= SEG_BLANK;
         frame_done_q <= 1'b0;
      end else begin
         an_q         <= an_d;
         seg_q        <= seg_d;
         frame_done_q <= frame_end;
      end
   end

   assign an         = an_q;
   assign seg        = seg_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with a time-based reference model.
module tb_seven_seg_scanner;

   localparam int N = 4;
   localparam int S = 8;
   localparam int G = 2;
   localparam int F = N * S;

   logic          clk;
   logic          rst;
   logic [4*N-1:0] bcd;
   logic [N-1:0]  dp_en;
   logic          blank_lz;
   logic          load;
   logic [N-1:0]  an;
   logic [7:0]    seg;
   logic          frame_done;

   int n_cmp = 0;
   int n_bad = 0;

   seven_seg_scanner #(.NUM_DIGITS(N), .SCAN_DIV(S), .GUARD(G)) dut (
      .clk        (clk),
      .rst        (rst),
      .bcd        (bcd),
      .dp_en      (dp_en),
      .blank_lz   (blank_lz),
      .load       (load),
      .an         (an),
      .seg        (seg),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [7:0] seg_tab [0:9] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
   int         m_t;
   logic       m_valid = 1'b0;
   logic [4*N-1:0] m_sh_bcd, m_st_bcd;
   logic [N-1:0]   m_sh_dp, m_st_dp;
   logic           m_sh_lz, m_st_lz, m_pend;
   logic [N-1:0]   e_an;
   logic [7:0]     e_seg;
   logic           e_fd;

   function automatic logic [7:0] model_seg(input int k);
      int         d;
      logic       blank;
      logic [6:0] low;
      d     = int'(m_sh_bcd[4*k +: 4]);
      blank = m_sh_lz && (k != 0);
      for (int j = k; j < N; j++)
         if (m_sh_bcd[4*j +: 4] != 4'd0) blank = 1'b0;
      if (d <= 9 && !blank) low = seg_tab[d][6:0];
      else                  low = 7'h7F;
      return {~m_sh_dp[k], low};
   endfunction

   // Position in time since reset decides which digit is shown and whether
   // the guard window is active; the shadow changes only at frame ends.
   always @(posedge clk) begin
      int d, o, fp;
      if (rst) begin
         m_t = 0; m_valid = 1'b1;
         m_sh_bcd = '0; m_sh_dp = '0; m_sh_lz = 1'b0; m_pend = 1'b0;
         m_st_bcd = '0; m_st_dp = '0; m_st_lz = 1'b0;
         e_an = 4'hF; e_seg = 8'hFF; e_fd = 1'b0;
      end else begin
         d  = (m_t / S) % N;
         o  = m_t % S;
         fp = m_t % F;
         e_an = 4'hF;
         if (o < G) begin
            e_seg = 8'hFF;
         end else begin
            e_an[d] = 1'b0;
            e_seg   = model_seg(d);
         end
         e_fd = (fp == F - 1);
         if (fp == F - 1 && m_pend) begin
            m_sh_bcd = m_st_bcd; m_sh_dp = m_st_dp; m_sh_lz = m_st_lz;
            m_pend = 1'b0;
         end
         if (load) begin
            m_st_bcd = bcd; m_st_dp = dp_en; m_st_lz = blank_lz;
            m_pend = 1'b1;
         end
         m_t++;
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (m_valid) begin
         n_cmp++;
         if (an !== e_an) begin
            n_bad++;
            $display("FAIL model_an t=%0d: got %b expected %b", m_t, an, e_an);
         end
         n_cmp++;
         if (seg !== e_seg) begin
            n_bad++;
            $display("FAIL model_seg t=%0d: got %h expected %h", m_t, seg, e_seg);
         end
         n_cmp++;
         if (frame_done !== e_fd) begin
            n_bad++;
            $display("FAIL model_fd t=%0d: got %b expected %b", m_t, frame_done, e_fd);
         end
         n_cmp++;
         if ($countones(~an) > 1) begin
            n_bad++;
            $display("FAIL onehot_an t=%0d: got %b expected at most one low", m_t, an);
         end
      end
   end

   // ---------------- directed helpers ----------------
   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end else begin
         $display("check %s: %h ok", nm, act);
      end
   endtask

   task automatic wait_digit(input int k, output int cycles);
      logic [N-1:0] want;
      logic         found;
      want  = 4'hF;
      want[k] = 1'b0;
      found = 1'b0;
      cycles = -1;
      for (int i = 0; i < 80 && !found; i++) begin
         @(negedge clk);
         if (an === want) begin
            found = 1'b1;
            cycles = i;
         end
      end
      if (!found) begin
         n_cmp++; n_bad++;
         $display("FAIL wait_digit%0d: got timeout expected anode %b", k, want);
      end
   endtask

   task automatic wait_fd();
      logic found;
      found = 1'b0;
      for (int i = 0; i < 80 && !found; i++) begin
         @(negedge clk);
         if (frame_done === 1'b1) found = 1'b1;
      end
      if (!found) begin
         n_cmp++; n_bad++;
         $display("FAIL wait_fd: got timeout expected frame_done pulse");
      end
   endtask

   task automatic do_load(input logic [15:0] b, input logic [3:0] dp, input logic lz);
      bcd = b; dp_en = dp; blank_lz = lz; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic check_frame(input string nm, input logic [7:0] e0, input logic [7:0] e1,
                              input logic [7:0] e2, input logic [7:0] e3);
      int c;
      logic [7:0] ex [4];
      ex[0] = e0; ex[1] = e1; ex[2] = e2; ex[3] = e3;
      for (int k = 0; k < N; k++) begin
         wait_digit(k, c);
         chk($sformatf("%s_d%0d", nm, k), seg, ex[k]);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int c;
      rst = 1'b1; bcd = '0; dp_en = '0; blank_lz = 1'b0; load = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_an", {4'h0, an}, 8'h0F);
      chk("reset_seg", seg, 8'hFF);
      chk("reset_fd", {7'h0, frame_done}, 8'h00);
      rst = 1'b0;

      // Guard covers the first two outputs after release.
      wait_digit(0, c);
      chk("first_digit_latency", 8'(c), 8'd2);
      chk("zero_digit0", seg, 8'hC0);
      check_frame("zeros_pre", 8'hC0, 8'hC0, 8'hC0, 8'hC0);

      // Mid-frame load must not change the current frame.
      wait_fd();
      do_load(16'h1234, 4'b0100, 1'b0);
      wait_digit(1, c);
      chk("old_frame_digit1", seg, 8'hC0);
      wait_fd();
      check_frame("v1234", 8'h99, 8'hB0, 8'h24, 8'hF9);

      // Leading-zero blanking.
      do_load(16'h0050, 4'b0000, 1'b1);
      wait_fd();
      check_frame("lz0050", 8'hC0, 8'h92, 8'hFF, 8'hFF);
      do_load(16'h0000, 4'b0000, 1'b1);
      wait_fd();
      check_frame("lz0000", 8'hC0, 8'hFF, 8'hFF, 8'hFF);

      // Non-decimal code with dp lit.
      do_load(16'h00A0, 4'b0010, 1'b0);
      wait_fd();
      check_frame("codeA_dp", 8'hC0, 8'h7F, 8'hC0, 8'hC0);

      // Two loads in one frame: last one wins.
      wait_fd();
      do_load(16'h1111, 4'b0000, 1'b0);
      repeat (5) @(negedge clk);
      do_load(16'h2222, 4'b0000, 1'b0);
      wait_fd();
      check_frame("last_wins", 8'hA4, 8'hA4, 8'hA4, 8'hA4);

      // Load on the boundary cycle is shown one frame later.
      wait_fd();
      do_load(16'h5555, 4'b0000, 1'b0);
      repeat (30) @(negedge clk);
      do_load(16'h3333, 4'b0000, 1'b0);
      chk("boundary_fd", {7'h0, frame_done}, 8'h01);
      check_frame("bnd_old", 8'h92, 8'h92, 8'h92, 8'h92);
      wait_fd();
      check_frame("bnd_new", 8'hB0, 8'hB0, 8'hB0, 8'hB0);

      // Reset while digit 2 is active with a load pending.
      wait_fd();
      do_load(16'h7777, 4'b1111, 1'b0);
      wait_digit(2, c);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_an", {4'h0, an}, 8'h0F);
      chk("midrst_seg", seg, 8'hFF);
      rst = 1'b0;
      check_frame("after_rst", 8'hC0, 8'hC0, 8'hC0, 8'hC0);
      wait_fd();
      check_frame("after_rst2", 8'hC0, 8'hC0, 8'hC0, 8'hC0);

      repeat (4) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected end of test");
      $fatal(1, "watchdog expired");
   end

endmodule
